instruction_phase_sequencer: RTL and testbench

Upstream stage of the I-decoder tree. Owns the opcode register (ITABLE), the execution-phase counter (XPT), the M1/fetch flag (CM1) and the previous-opcode latch (OPOPold); feeds true/complement copies of these to the decoder. Consumes the decoder's end-of-instruction strobes (PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd), closing the fetch/execute loop.

---
 rtl/norz_seq_pkg.sv | 14 +
 rtl/norz_phase_counter.sv | 36 +++
 rtl/instruction_phase_sequencer.sv | 112 +++++++++++
 tb/tb_instruction_phase_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/norz_seq_pkg.sv
// Shared types and defaults for the instruction phase sequencer.
// Build option: NORZ_PHASE_WATCHDOG_EN enables the phase-overflow watchdog.
package norz_seq_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } seq_state_e;

    localparam int              XPT_WIDTH_DEF    = 4;
    localparam int              OP_WIDTH_DEF     = 8;
    localparam logic [7:0]      RESET_OPCODE_DEF = 8'h00;

endpackage

// File: rtl/norz_phase_counter.sv
// Execution-phase counter: clear has priority over increment, otherwise holds.
// Latency: one cycle; all_ones_o flags the value at which the next increment wraps.
module norz_phase_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] xpt_o,
    output logic         all_ones_o
);

    logic [W-1:0] xpt_q, xpt_d;

    always_comb begin
        xpt_d = xpt_q;
        if (clr_i) begin
            xpt_d = '0;
        end else if (inc_i) begin
            xpt_d = xpt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            xpt_q <= '0;
        end else begin
            xpt_q <= xpt_d;
        end
    end

    assign xpt_o      = xpt_q;
    assign all_ones_o = &xpt_q;

endmodule

// File: rtl/instruction_phase_sequencer.sv
// Fetch/execute sequencer owning ITABLE, XPT, CM1 and OPOPold for the I-decoder tree.
// Build option: NORZ_PHASE_WATCHDOG_EN turns XPT overflow into a sticky PHASE_ERR plus forced refetch.
module instruction_phase_sequencer
    import norz_seq_pkg::*;
#(
    parameter int                  XPT_WIDTH    = XPT_WIDTH_DEF,
    parameter int                  OP_WIDTH     = OP_WIDTH_DEF,
    parameter logic [OP_WIDTH-1:0] RESET_OPCODE = RESET_OPCODE_DEF
) (
    input  logic                 CLK,
    input  logic                 notRESET,
    input  logic [OP_WIDTH-1:0]  DATA_IN,
    input  logic                 MEM_READY,
    input  logic                 PR_Reset_XPT,
    input  logic                 P2_Set_CM1,
    input  logic                 P2_Reset_ITABLE,
    input  logic                 Pa_Ophd,
    output logic                 FETCH_REQ,
    output logic                 CM1,
    output logic                 DEC_ENABLE,
    output logic [XPT_WIDTH-1:0] XPT,
    output logic [XPT_WIDTH-1:0] notXPT,
    output logic [OP_WIDTH-1:0]  ITABLE,
    output logic [OP_WIDTH-1:0]  notITABLE,
    output logic [OP_WIDTH-1:0]  OPOPold,
    output logic                 PHASE_ERR
);

    seq_state_e          state_q, state_d;
    logic [OP_WIDTH-1:0] itable_q, itable_d;
    logic [OP_WIDTH-1:0] opopold_q, opopold_d;
    logic                exec_go, xpt_all_ones, wd_trip, xpt_clr, xpt_inc;

    // Strobes only count while executing with the bus ready.
    assign exec_go = (state_q == EXEC) && MEM_READY;

`ifdef NORZ_PHASE_WATCHDOG_EN
    logic err_q;
    assign wd_trip = exec_go && !P2_Set_CM1 && !PR_Reset_XPT && xpt_all_ones;

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            err_q <= 1'b0;
        end else if (wd_trip) begin
            err_q <= 1'b1;
        end
    end
    assign PHASE_ERR = err_q;
`else
    assign wd_trip   = 1'b0;
    assign PHASE_ERR = 1'b0;
`endif

    assign xpt_clr = (state_q == FETCH) || (exec_go && (P2_Set_CM1 || PR_Reset_XPT || wd_trip));
    assign xpt_inc = exec_go;

    norz_phase_counter #(.W(XPT_WIDTH)) u_xpt (
        .clk_i      (CLK),
        .rst_n_i    (notRESET),
        .clr_i      (xpt_clr),
        .inc_i      (xpt_inc),
        .xpt_o      (XPT),
        .all_ones_o (xpt_all_ones)
    );

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state_q   <= FETCH;
            itable_q  <= RESET_OPCODE;
            opopold_q <= '0;
        end else begin
            state_q   <= state_d;
            itable_q  <= itable_d;
            opopold_q <= opopold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (MEM_READY) state_d = EXEC;
            EXEC:    if (exec_go && (P2_Set_CM1 || wd_trip)) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        itable_d  = itable_q;
        opopold_d = opopold_q;
        if ((state_q == FETCH) && MEM_READY) begin
            itable_d = DATA_IN;
        end
        if (exec_go && (P2_Reset_ITABLE || wd_trip)) begin
            itable_d = RESET_OPCODE;
        end
        if (exec_go && Pa_Ophd) begin
            opopold_d = itable_q;
        end
    end

    always_comb begin
        CM1        = (state_q == FETCH);
        FETCH_REQ  = (state_q == FETCH);
        DEC_ENABLE = exec_go;
    end

    assign ITABLE    = itable_q;
    assign notITABLE = ~itable_q;
    assign notXPT    = ~XPT;
    assign OPOPold   = opopold_q;

endmodule

// File: tb/tb_instruction_phase_sequencer.sv
// Directed-vector bench for instruction_phase_sequencer (default parameters).
module tb_instruction_phase_sequencer;

    logic       CLK = 1'b0;
    logic       notRESET;
    logic [7:0] DATA_IN;
    logic       MEM_READY, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd;
    logic       FETCH_REQ, CM1, DEC_ENABLE, PHASE_ERR;
    logic [3:0] XPT, notXPT;
    logic [7:0] ITABLE, notITABLE, OPOPold;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    instruction_phase_sequencer dut (
        .CLK             (CLK),
        .notRESET        (notRESET),
        .DATA_IN         (DATA_IN),
        .MEM_READY       (MEM_READY),
        .PR_Reset_XPT    (PR_Reset_XPT),
        .P2_Set_CM1      (P2_Set_CM1),
        .P2_Reset_ITABLE (P2_Reset_ITABLE),
        .Pa_Ophd         (Pa_Ophd),
        .FETCH_REQ       (FETCH_REQ),
        .CM1             (CM1),
        .DEC_ENABLE      (DEC_ENABLE),
        .XPT             (XPT),
        .notXPT          (notXPT),
        .ITABLE          (ITABLE),
        .notITABLE       (notITABLE),
        .OPOPold         (OPOPold),
        .PHASE_ERR       (PHASE_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic strobes(input logic v);
        PR_Reset_XPT    = v;
        P2_Set_CM1      = v;
        P2_Reset_ITABLE = v;
        Pa_Ophd         = v;
    endtask

    initial begin
        notRESET  = 1'b0;
        DATA_IN   = 8'h00;
        MEM_READY = 1'b0;
        strobes(1'b0);
        tick(3);
        chk("rst_notITABLE", notITABLE, 8'hFF);
        chk("rst_notXPT", notXPT, 4'hF);

        // Reset release, bus idle
        notRESET = 1'b1;
        tick(1);
        chk("idle_CM1", CM1, 1);
        chk("idle_FETCH_REQ", FETCH_REQ, 1);
        chk("idle_XPT", XPT, 0);
        chk("idle_ITABLE", ITABLE, 8'h00);
        chk("idle_notITABLE", notITABLE, 8'hFF);
        chk("idle_DEC_ENABLE", DEC_ENABLE, 0);

        // Opcode fetch 1D
        DATA_IN   = 8'h1D;
        MEM_READY = 1'b1;
        tick(1);
        chk("f1_CM1", CM1, 0);
        chk("f1_ITABLE", ITABLE, 8'h1D);
        chk("f1_notITABLE", notITABLE, 8'hE2);
        chk("f1_XPT", XPT, 0);
        chk("f1_DEC_ENABLE", DEC_ENABLE, 1);
        tick(2);
        chk("run_XPT2", XPT, 2);

        // Stall at XPT=2 with strobes asserted: must be ignored
        MEM_READY = 1'b0;
        strobes(1'b1);
        #1;
        chk("stall_DEC_ENABLE", DEC_ENABLE, 0);
        tick(4);
        chk("stall_XPT", XPT, 2);
        chk("stall_CM1", CM1, 0);
        chk("stall_ITABLE", ITABLE, 8'h1D);
        chk("stall_OPOPold", OPOPold, 8'h00);
        strobes(1'b0);
        MEM_READY = 1'b1;
        tick(1);
        chk("resume_XPT", XPT, 3);
        tick(1);
        chk("run_XPT4", XPT, 4);

        // PR_Reset_XPT alone
        PR_Reset_XPT = 1'b1;
        tick(1);
        PR_Reset_XPT = 1'b0;
        chk("prx_XPT", XPT, 0);
        chk("prx_CM1", CM1, 0);
        chk("prx_ITABLE", ITABLE, 8'h1D);

        // End instruction at XPT=0, then fetch 1F
        strobes(1'b1);
        tick(1);
        strobes(1'b0);
        chk("eoi1_CM1", CM1, 1);
        chk("eoi1_ITABLE", ITABLE, 8'h00);
        chk("eoi1_OPOPold", OPOPold, 8'h1D);
        DATA_IN = 8'h1F;
        tick(1);
        chk("f2_ITABLE", ITABLE, 8'h1F);
        tick(5);
        chk("f2_XPT5", XPT, 5);

        // Full end-of-instruction at XPT=5
        strobes(1'b1);
        tick(1);
        strobes(1'b0);
        chk("eoi2_CM1", CM1, 1);
        chk("eoi2_XPT", XPT, 0);
        chk("eoi2_notXPT", notXPT, 4'hF);
        chk("eoi2_ITABLE", ITABLE, 8'h00);
        chk("eoi2_OPOPold", OPOPold, 8'h1F);

        // Phase overflow
        DATA_IN = 8'hA5;
        tick(1);
        chk("f3_ITABLE", ITABLE, 8'hA5);
        tick(15);
        chk("ovf_XPT15", XPT, 4'hF);
        chk("ovf_notXPT", notXPT, 4'h0);
        tick(1);
        chk("ovf_XPT", XPT, 0);
`ifdef NORZ_PHASE_WATCHDOG_EN
        chk("ovf_PHASE_ERR", PHASE_ERR, 1);
        chk("ovf_CM1", CM1, 1);
        chk("ovf_ITABLE", ITABLE, 8'h00);
        DATA_IN = 8'h3C;
        tick(1);
        chk("ovf_sticky", PHASE_ERR, 1);
`else
        chk("ovf_PHASE_ERR", PHASE_ERR, 0);
        chk("ovf_CM1", CM1, 0);
        chk("ovf_ITABLE", ITABLE, 8'hA5);
`endif
        tick(3);

        // Asynchronous reset mid-run
        #2;
        notRESET = 1'b0;
        #1;
        chk("arst_CM1", CM1, 1);
        chk("arst_XPT", XPT, 0);
        chk("arst_ITABLE", ITABLE, 8'h00);
        chk("arst_OPOPold", OPOPold, 8'h00);
        chk("arst_PHASE_ERR", PHASE_ERR, 0);
        MEM_READY = 1'b0;
        tick(1);
        notRESET = 1'b1;
        tick(1);
        chk("rel_CM1", CM1, 1);
        chk("rel_DEC_ENABLE", DEC_ENABLE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
